// File: rtl/melody_pkg.sv
// Shared types and tables for the melody sequencer: pitch dividers, display codes, FSM states.
package melody_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [7:0] END_MARKER = 8'h00;

  localparam logic [5:0] CH_4    = 6'd4;
  localparam logic [5:0] CH_5    = 6'd5;
  localparam logic [5:0] CH_6    = 6'd6;
  localparam logic [5:0] CH_A    = 6'd10;
  localparam logic [5:0] CH_B    = 6'd11;
  localparam logic [5:0] CH_C    = 6'd12;
  localparam logic [5:0] CH_D    = 6'd13;
  localparam logic [5:0] CH_E    = 6'd14;
  localparam logic [5:0] CH_F    = 6'd15;
  localparam logic [5:0] CH_G    = 6'd16;
  localparam logic [5:0] CH_DASH = 6'd36;

  // round(100 MHz / f_note)
  localparam logic [19:0] DIV_TABLE [0:15] = '{
    20'd0,
    20'd382219, 20'd340530, 20'd303370, 20'd286344, 20'd255102, 20'd227273, 20'd202478,
    20'd191113, 20'd170262, 20'd151688, 20'd143172, 20'd127553, 20'd113636, 20'd101238,
    20'd95557
  };

  localparam logic [11:0] DISP_TABLE [0:15] = '{
    {CH_DASH, CH_DASH},
    {CH_C, CH_4}, {CH_D, CH_4}, {CH_E, CH_4}, {CH_F, CH_4}, {CH_G, CH_4}, {CH_A, CH_4}, {CH_B, CH_4},
    {CH_C, CH_5}, {CH_D, CH_5}, {CH_E, CH_5}, {CH_F, CH_5}, {CH_G, CH_5}, {CH_A, CH_5}, {CH_B, CH_5},
    {CH_C, CH_6}
  };

  function automatic logic [3:0] sat_idx(logic [4:0] p);
    return (p > 5'd15) ? 4'd15 : p[3:0];
  endfunction

  // Right channel sits a third (two scale steps) above, clamped at the top of the table.
  function automatic logic [3:0] right_idx(logic [4:0] p, logic chorus);
    if (!chorus || p == 5'd0) return sat_idx(p);
    return (p >= 5'd13) ? 4'd15 : 4'(p + 5'd2);
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody ROM: word = {pitch[4:0], len[2:0]}; 8'h00 terminates the tune.
module melody_rom
  import melody_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        word
);

  always_comb begin
    case (addr)
      ADDR_W'(0): word = {5'd1, 3'd2};
      ADDR_W'(1): word = {5'd0, 3'd1};
      default:    word = END_MARKER;
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Picks the current note (keypad or ROM playback) and registers per-channel dividers and display codes.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_CYC = 5_000_000,
  parameter int GAP_CYC  = 1_000_000,
  parameter int ADDR_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key,
  input  logic        pressed,
  input  logic        mode_auto,
  input  logic        chorus,
  input  logic        start,
  input  logic        loop_en,
  output logic [19:0] note_data_left,
  output logic [19:0] note_data_right,
  output logic [11:0] note_disp_left,
  output logic [11:0] note_disp_right,
  output logic        busy
);

  localparam logic [25:0] BEAT_W   = 26'(BEAT_CYC);
  localparam logic [25:0] GAP_W    = 26'(GAP_CYC);
  localparam logic [25:0] GAP_LAST = 26'(GAP_CYC - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic [25:0]       cnt_q, cnt_d, note_cyc;
  logic [2:0]        len_q, len_d;
  logic [7:0]        word_nxt, word_out;
  logic [4:0]        p_d;
  logic [3:0]        pl, pr;
  logic [19:0]       left_q, left_d, right_q, right_d;
  logic [11:0]       disp_l_q, disp_l_d, disp_r_q, disp_r_d;
  logic              busy_q, busy_d;

  assign addr_nxt = addr_q + 1'b1;

  // Lookahead ROM decides end-of-tune; the second one supplies the word being entered.
  melody_rom #(.ADDR_W(ADDR_W)) u_rom_nxt (.addr(addr_nxt), .word(word_nxt));
  melody_rom #(.ADDR_W(ADDR_W)) u_rom_out (.addr(addr_d),   .word(word_out));

  assign note_cyc = ((len_q == 3'd0) ? 26'd1 : 26'(len_q)) * BEAT_W - GAP_W;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (!mode_auto) begin
      state_d = S_IDLE;
      addr_d  = '0;
      cnt_d   = '0;
    end else if (start) begin
      state_d = S_NOTE;
      addr_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_NOTE: begin
          if (cnt_q == note_cyc - 26'd1) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (word_nxt != END_MARKER) begin
              addr_d  = addr_nxt;
              state_d = S_NOTE;
            end else if (loop_en) begin
              addr_d  = '0;
              state_d = S_NOTE;
            end else begin
              addr_d  = addr_nxt;
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Keypad only drives the note once the FSM has settled back in IDLE, so leaving
  // auto mode always yields one silent cycle first.
  always_comb begin
    p_d = '0;
    if (state_q == S_IDLE && !mode_auto) begin
      if (pressed) p_d = {1'b0, key};
    end else if (state_d == S_NOTE) begin
      p_d = word_out[7:3];
    end
    len_d    = word_out[2:0];
    pl       = sat_idx(p_d);
    pr       = right_idx(p_d, chorus);
    left_d   = DIV_TABLE[pl];
    right_d  = DIV_TABLE[pr];
    disp_l_d = DISP_TABLE[pl];
    disp_r_d = DISP_TABLE[pr];
    busy_d   = (state_d == S_NOTE) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      disp_l_q <= {CH_DASH, CH_DASH};
      disp_r_q <= {CH_DASH, CH_DASH};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      left_q   <= left_d;
      right_q  <= right_d;
      disp_l_q <= disp_l_d;
      disp_r_q <= disp_r_d;
      busy_q   <= busy_d;
    end
  end

  assign note_data_left  = left_q;
  assign note_data_right = right_q;
  assign note_disp_left  = disp_l_q;
  assign note_disp_right = disp_r_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: manual vector table, directed auto sequences, random vs model.
module tb_melody_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key = '0;
  logic        pressed = 1'b0, mode_auto = 1'b0, chorus = 1'b0, start = 1'b0, loop_en = 1'b0;
  logic [19:0] note_data_left, note_data_right;
  logic [11:0] note_disp_left, note_disp_right;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  melody_sequencer #(.BEAT_CYC(BEAT), .GAP_CYC(GAP), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .pressed(pressed), .mode_auto(mode_auto),
    .chorus(chorus), .start(start), .loop_en(loop_en),
    .note_data_left(note_data_left), .note_data_right(note_data_right),
    .note_disp_left(note_disp_left), .note_disp_right(note_disp_right), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam logic [5:0] C_DASH = 6'd36;
  localparam int DIV [16] = '{0, 382219, 340530, 303370, 286344, 255102, 227273, 202478,
                              191113, 170262, 151688, 143172, 127553, 113636, 101238, 95557};
  localparam int LETTER [7] = '{12, 13, 14, 15, 16, 10, 11};  // C D E F G A B

  // The tune the ROM is expected to hold: {pitch, length in beats}
  localparam int N_NOTES = 2;
  localparam int TUNE_P [N_NOTES] = '{1, 0};
  localparam int TUNE_L [N_NOTES] = '{2, 1};

  function automatic logic [19:0] div_of(int p);
    return 20'(DIV[p]);
  endfunction

  function automatic logic [11:0] disp_of(int p);
    if (p == 0) return {C_DASH, C_DASH};
    return {6'(LETTER[(p - 1) % 7]), 6'(4 + (p - 1) / 7)};
  endfunction

  function automatic int right_of(int p, logic ch);
    if (!ch || p == 0) return p;
    return (p + 2 > 15) ? 15 : p + 2;
  endfunction

  function automatic int tune_period();
    int s = 0;
    for (int i = 0; i < N_NOTES; i++) s += TUNE_L[i] * BEAT;
    return s;
  endfunction

  // Pitch heard t cycles after the tune starts; -1 once past the end.
  function automatic int p_at(int t);
    int r = t;
    for (int i = 0; i < N_NOTES; i++) begin
      if (r < TUNE_L[i] * BEAT - GAP) return TUNE_P[i];
      r -= TUNE_L[i] * BEAT - GAP;
      if (r < GAP) return 0;
      r -= GAP;
    end
    return -1;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int pl, input int pr, input logic b);
    chk({tag, ".left"},  32'(note_data_left),  32'(div_of(pl)));
    chk({tag, ".right"}, 32'(note_data_right), 32'(div_of(pr)));
    chk({tag, ".displ"}, 32'(note_disp_left),  32'(disp_of(pl)));
    chk({tag, ".dispr"}, 32'(note_disp_right), 32'(disp_of(pr)));
    chk({tag, ".busy"},  32'(busy),            32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  key;
    logic        pressed;
    logic        chorus;
    int          exp_l;
    int          exp_r;
    logic [11:0] dl;
    logic [11:0] dr;
  } vec_t;

  vec_t vt [8];

  initial begin
    int per, t, p;
    logic act, ch;

    // Hand-written expectations, chars: C=12 D=13 E=14 A=10 B=11, digits = value, dash = 36
    vt[0] = '{4'd6,  1'b1, 1'b0, 227273, 227273, {6'd10, 6'd4}, {6'd10, 6'd4}};
    vt[1] = '{4'd6,  1'b1, 1'b1, 227273, 191113, {6'd10, 6'd4}, {6'd12, 6'd5}};
    vt[2] = '{4'd0,  1'b1, 1'b1, 0,      0,      {C_DASH, C_DASH}, {C_DASH, C_DASH}};
    vt[3] = '{4'd6,  1'b0, 1'b1, 0,      0,      {C_DASH, C_DASH}, {C_DASH, C_DASH}};
    vt[4] = '{4'd15, 1'b1, 1'b1, 95557,  95557,  {6'd12, 6'd6}, {6'd12, 6'd6}};
    vt[5] = '{4'd14, 1'b1, 1'b1, 101238, 95557,  {6'd11, 6'd5}, {6'd12, 6'd6}};
    vt[6] = '{4'd1,  1'b1, 1'b1, 382219, 303370, {6'd12, 6'd4}, {6'd14, 6'd4}};
    vt[7] = '{4'd8,  1'b1, 1'b0, 191113, 191113, {6'd12, 6'd5}, {6'd12, 6'd5}};

    per = tune_period();

    // Reset state
    #12;
    chk_out("rst_hold", 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("rst_rel", 0, 0, 1'b0);

    // Manual table; start pulses must be ignored here
    for (int i = 0; i < 8; i++) begin
      key = vt[i].key; pressed = vt[i].pressed; chorus = vt[i].chorus; start = i[0];
      tick();
      chk($sformatf("man%0d.left", i),  32'(note_data_left),  32'(vt[i].exp_l));
      chk($sformatf("man%0d.right", i), 32'(note_data_right), 32'(vt[i].exp_r));
      chk($sformatf("man%0d.displ", i), 32'(note_disp_left),  32'(vt[i].dl));
      chk($sformatf("man%0d.dispr", i), 32'(note_disp_right), 32'(vt[i].dr));
      chk($sformatf("man%0d.busy", i),  32'(busy),            32'(0));
    end
    start = 1'b0;

    // Manual random
    for (int i = 0; i < 150; i++) begin
      key = 4'($urandom_range(0, 15)); pressed = 1'($urandom); chorus = 1'($urandom);
      start = ($urandom_range(0, 7) == 0);
      tick();
      p = pressed ? int'(key) : 0;
      chk("man_rand", 32'(note_data_left), 32'(div_of(p)));
      chk_out("man_rand", p, right_of(p, chorus), 1'b0);
    end
    start = 1'b0; pressed = 1'b0; chorus = 1'b0;
    tick();

    // Auto, single pass
    mode_auto = 1'b1; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (t = 0; t < per + 5; t++) begin
      p = (t < per) ? p_at(t) : 0;
      chk_out("once", p, p, t < per);
      tick();
    end

    // Auto, looping with no extra gap between passes
    loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (t = 0; t < 2 * per + 10; t++) begin
      p = p_at(t % per);
      chk_out("loop", p, p, 1'b1);
      tick();
    end

    // Restart mid-note (first note mid-way) and mid-rest
    start = 1'b1; tick(); start = 1'b0;
    for (t = 0; t < 22; t++) begin
      chk_out("rs_note", p_at(t), p_at(t), 1'b1);
      tick();
    end
    start = 1'b1; tick(); start = 1'b0;
    for (t = 0; t < 10; t++) begin
      chk_out("rs_rest", p_at(t), p_at(t), 1'b1);
      tick();
    end

    // Leave auto mid-note: one silent cycle, then keypad takes over
    mode_auto = 1'b0; key = 4'd6; pressed = 1'b1;
    tick();
    chk_out("mfall0", 0, 0, 1'b0);
    tick();
    chk_out("mfall1", 6, 6, 1'b0);

    // Async reset during GAP
    pressed = 1'b0; mode_auto = 1'b1; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("pre_rst0", p_at(0), p_at(0), 1'b1);
    for (t = 0; t < BEAT * TUNE_L[0] - GAP; t++) tick();
    chk_out("pre_rst_gap", 0, 0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 0, 0, 1'b0);
    tick();
    chk_out("rst_held", 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("rst_idle", 0, 0, 1'b0);

    // Random auto against the timeline model
    for (int seg = 0; seg < 2; seg++) begin
      loop_en = seg[0];
      t = 0;
      for (int i = 0; i < 160; i++) begin
        start = (i == 0) || ($urandom_range(0, 24) == 0);
        ch = 1'($urandom); chorus = ch;
        key = 4'($urandom_range(0, 15)); pressed = 1'($urandom);
        tick();
        t = start ? 0 : t + 1;
        act = loop_en || (t < per);
        p = act ? p_at(t % per) : 0;
        chk_out("auto_rand", p, right_of(p, ch), act);
      end
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
